// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the buffered UART receiver.
//   PARITY_*        frame parity modes
//   rx_state_t      receiver FSM state encoding
//   clks_per_bit()  rounded clock-to-baud ratio
//   entry_width()   FIFO entry width: data plus frame/parity error flags
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK_WAIT
    } rx_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

    function automatic int entry_width(input int data_bits);
        return data_bits + 2;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// sync_fifo: single-clock show-ahead FIFO.
//   clk, rst_n     clock, async active-low reset (flushes the FIFO)
//   i_push         write i_push_data; ignored when full unless popping too
//   i_pop          remove head entry; ignored when empty
//   o_head         current head entry (0 while empty)
//   o_full/o_empty occupancy flags
//   o_count        entries held, 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = i_pop && !w_empty;
    // A pop in the same cycle frees the slot the push lands in.
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + COUNT_ONE;
                2'b01:   r_count <= r_count - COUNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver with configurable frame format and a
// show-ahead character FIFO on the output.
//   clk, rst_n      system clock, async active-low reset
//   rx_in           raw serial line (asynchronous, idle high)
//   rx_data         head character; rx_frame_err / rx_parity_err its flags
//   rx_valid        FIFO non-empty; rx_ready pops the head entry
//   fifo_count      entries held
//   overrun         sticky drop indicator, cleared by overrun_clr
//
// state          | meaning
// ST_IDLE        | line idle, waiting for a falling edge
// ST_START       | half a bit in, confirm start bit (reject glitches)
// ST_DATA        | sample DATA_BITS bits, LSB first
// ST_PARITY      | sample the parity bit
// ST_STOP        | sample stop bit(s); push entry at the last one
// ST_BREAK_WAIT  | last stop bit was low, wait for line to return high
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_in,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_frame_err,
    output logic                          rx_parity_err,
    output logic                          rx_valid,
    input  logic                          rx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    input  logic                          overrun_clr
);

    // CPB must be >= 4 so the half-bit start check lands before the bit ends.
    localparam int CPB = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CW  = $clog2(CPB);
    localparam int BW  = $clog2(DATA_BITS);
    localparam int EW  = entry_width(DATA_BITS);

    localparam logic [CW-1:0] CNT_HALF  = CW'(CPB / 2);
    localparam logic [CW-1:0] CNT_FULL  = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic          STOP_LAST = (STOP_BITS == 2);

    logic                 r_rx_meta;
    logic                 r_rx_s;

    rx_state_t            r_state;
    logic [CW-1:0]        r_cnt;
    logic [BW-1:0]        r_bit_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    logic                 w_tick;
    logic                 w_last_stop;
    logic                 w_parity_err;
    logic                 w_push;
    logic [EW-1:0]        w_push_data;
    logic [EW-1:0]        w_head;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_drop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_in;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_tick       = (r_cnt == '0);
    assign w_last_stop  = (r_stop_idx == STOP_LAST);
    // Odd parity expects an odd total count of ones over data plus parity bit.
    assign w_parity_err = ((^r_shift) ^ r_rx_s) != (PARITY == PARITY_ODD);

    // Push is combinational on the last stop mid-sample so the entry is
    // visible one cycle later.
    assign w_push      = (r_state == ST_STOP) && w_tick && w_last_stop;
    assign w_push_data = {r_frame_err | ~r_rx_s, r_parity_err, r_shift};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_stop_idx   <= 1'b0;
            r_shift      <= '0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= ST_START;
                        r_cnt   <= CNT_HALF;
                    end
                end
                ST_START: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end else if (r_rx_s) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_state      <= ST_DATA;
                        r_cnt        <= CNT_FULL;
                        r_bit_idx    <= '0;
                        r_stop_idx   <= 1'b0;
                        r_frame_err  <= 1'b0;
                        r_parity_err <= 1'b0;
                    end
                end
                ST_DATA: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end else begin
                        r_cnt   <= CNT_FULL;
                        r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit_idx == BIT_LAST) begin
                            r_state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + BIT_ONE;
                        end
                    end
                end
                ST_PARITY: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end else begin
                        r_cnt        <= CNT_FULL;
                        r_parity_err <= w_parity_err;
                        r_state      <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (!w_tick) begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end else begin
                        r_cnt <= CNT_FULL;
                        if (!r_rx_s) begin
                            r_frame_err <= 1'b1;
                        end
                        if (w_last_stop) begin
                            r_state <= r_rx_s ? ST_IDLE : ST_BREAK_WAIT;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                end
                ST_BREAK_WAIT: begin
                    if (r_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (rx_ready),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (fifo_count)
    );

    assign w_drop = w_push && w_full && !(rx_ready && !w_empty);

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (overrun_clr) begin
            r_overrun <= 1'b0;
        end
    end

    assign rx_valid      = !w_empty;
    assign rx_data       = w_head[DATA_BITS-1:0];
    assign rx_parity_err = w_head[DATA_BITS];
    assign rx_frame_err  = w_head[DATA_BITS+1];
    assign overrun       = r_overrun;

endmodule
